// File: rtl/spin_array_if.sv
// spin_array_if: control, beat and readout signals of the spin accumulator array
interface spin_array_if #(
    parameter int WIDTH  = 32,
    parameter int SPINS  = 32,
    parameter int STEP_W = 16,
    parameter int FLIP_W = 16
);
    logic                   load_en;
    logic [WIDTH-1:0]       load_value;
    logic                   start;
    logic [STEP_W-1:0]      steps;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       increment;
    logic [SPINS*WIDTH-1:0] coupling;
    logic [SPINS*WIDTH-1:0] value;
    logic [SPINS-1:0]       spin;
    logic                   busy;
    logic                   done;
    logic [FLIP_W-1:0]      flip_count;
    modport master (
        output load_en, load_value, start, steps, in_valid, increment, coupling,
        input  in_ready, value, spin, busy, done, flip_count
    );
    modport slave (
        input  load_en, load_value, start, steps, in_valid, increment, coupling,
        output in_ready, value, spin, busy, done, flip_count
    );
endinterface

// File: rtl/spin_array.sv
// spin_array: signed spin accumulators updated by coupling beats over a fixed-length run,
// counting spin sign flips per run.
module spin_array #(
    parameter int WIDTH    = 32,
    parameter int SPINS    = 32,
    parameter bit SATURATE = 1'b1,
    parameter int STEP_W   = 16,
    parameter int FLIP_W   = 16
) (
    input logic         clk,
    input logic         rst,
    spin_array_if.slave bus
);
    localparam int PW = $clog2(SPINS + 1);
    localparam int FW = FLIP_W + PW + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                 state_q, state_d;
    logic [STEP_W-1:0]      cnt_q, cnt_d;
    logic [FLIP_W-1:0]      flip_q, flip_d;
    logic [SPINS*WIDTH-1:0] value_q, value_d, value_n;
    logic [SPINS-1:0]       flipped;
    logic [PW-1:0]          pop;
    logic [FW-1:0]          fsum;

    // Two guard bits hold the sum of three WIDTH-bit signed terms exactly
    for (genvar s = 0; s < SPINS; s++) begin : g_spin
        logic [WIDTH-1:0] cur, cpl, res;
        logic [WIDTH+1:0] sum;
        logic             ovf;
        assign cur = value_q[s*WIDTH +: WIDTH];
        assign cpl = bus.coupling[s*WIDTH +: WIDTH];
        assign sum = {{2{cur[WIDTH-1]}}, cur} + {{2{bus.increment[WIDTH-1]}}, bus.increment}
                   + {{2{cpl[WIDTH-1]}}, cpl};
        assign ovf = SATURATE && (|sum[WIDTH+1:WIDTH-1]) && !(&sum[WIDTH+1:WIDTH-1]);
        assign res = ovf ? {sum[WIDTH+1], {(WIDTH-1){~sum[WIDTH+1]}}} : sum[WIDTH-1:0];
        assign value_n[s*WIDTH +: WIDTH] = res;
        assign flipped[s] = res[WIDTH-1] ^ cur[WIDTH-1];
        assign bus.spin[s] = ~cur[WIDTH-1];
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < SPINS; i++) pop = pop + PW'(flipped[i]);
    end

    assign fsum = FW'(flip_q) + FW'(pop);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flip_d  = flip_q;
        value_d = value_q;
        case (state_q)
            IDLE: begin
                if (bus.load_en) value_d = {SPINS{bus.load_value}};
                if (bus.start) begin
                    flip_d  = '0;
                    cnt_d   = bus.steps;
                    state_d = (bus.steps != '0) ? RUN : DONE;
                end
            end
            RUN: if (bus.in_valid) begin
                value_d = value_n;
                flip_d  = (|fsum[FW-1:FLIP_W]) ? '1 : fsum[FLIP_W-1:0];
                cnt_d   = cnt_q - STEP_W'(1);
                state_d = (cnt_q == STEP_W'(1)) ? DONE : RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flip_q  <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flip_q  <= flip_d;
            value_q <= value_d;
        end
    end

    assign bus.in_ready   = state_q == RUN;
    assign bus.busy       = state_q == RUN;
    assign bus.done       = state_q == DONE;
    assign bus.value      = value_q;
    assign bus.flip_count = flip_q;
endmodule

// File: tb/tb_spin_array.sv
// tb_spin_array: directed bench driving a saturating and a wrapping instance in lockstep
// against a small behavioural model of the accumulators and flip counter.
module tb_spin_array;
    localparam int W = 8, N = 4, SW = 4, FW = 3;
    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total = 0;
    int   mv[2][N];
    int   mf[2];
    typedef struct {
        logic [N*W-1:0] v0, v1;
        logic [N-1:0]   s0, s1;
        logic [FW-1:0]  f0, f1;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    spin_array_if #(.WIDTH(W), .SPINS(N), .STEP_W(SW), .FLIP_W(FW)) ia ();
    spin_array_if #(.WIDTH(W), .SPINS(N), .STEP_W(SW), .FLIP_W(FW)) ib ();

    spin_array #(.WIDTH(W), .SPINS(N), .SATURATE(1'b1), .STEP_W(SW), .FLIP_W(FW)) u_sat (
        .clk(clk), .rst(rst), .bus(ia.slave));
    spin_array #(.WIDTH(W), .SPINS(N), .SATURATE(1'b0), .STEP_W(SW), .FLIP_W(FW)) u_wrap (
        .clk(clk), .rst(rst), .bus(ib.slave));

    assign ib.load_en    = ia.load_en;
    assign ib.load_value = ia.load_value;
    assign ib.start      = ia.start;
    assign ib.steps      = ia.steps;
    assign ib.in_valid   = ia.in_valid;
    assign ib.increment  = ia.increment;
    assign ib.coupling   = ia.coupling;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t snap();
        exp_t e;
        for (int s = 0; s < N; s++) begin
            e.v0[s*W +: W] = W'(mv[0][s]);
            e.v1[s*W +: W] = W'(mv[1][s]);
            e.s0[s] = mv[0][s] >= 0;
            e.s1[s] = mv[1][s] >= 0;
        end
        e.f0 = FW'(mf[0]);
        e.f1 = FW'(mf[1]);
        return e;
    endfunction

    task automatic compare(exp_t e, string tag);
        chk({tag, "/val_sat"}, ia.value, e.v0);
        chk({tag, "/val_wrap"}, ib.value, e.v1);
        chk({tag, "/spin_sat"}, 32'(ia.spin), 32'(e.s0));
        chk({tag, "/spin_wrap"}, 32'(ib.spin), 32'(e.s1));
        chk({tag, "/flip_sat"}, 32'(ia.flip_count), 32'(e.f0));
        chk({tag, "/flip_wrap"}, 32'(ib.flip_count), 32'(e.f1));
    endtask

    function automatic void model_set(int v, bit clr_flip);
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < N; s++) mv[d][s] = v;
            if (clr_flip) mf[d] = 0;
        end
    endfunction

    function automatic void model_beat(int inc, logic [N*W-1:0] cpl);
        for (int d = 0; d < 2; d++) begin
            int fl = 0;
            for (int s = 0; s < N; s++) begin
                int o = mv[d][s];
                int n = o + inc + int'($signed(cpl[s*W +: W]));
                if (d == 0) n = n > 127 ? 127 : (n < -128 ? -128 : n);
                else n = ((n + 128) % 256 + 256) % 256 - 128;
                if ((o < 0) != (n < 0)) fl++;
                mv[d][s] = n;
            end
            mf[d] = (mf[d] + fl > 7) ? 7 : mf[d] + fl;
        end
    endfunction

    task automatic beat(int inc, logic [N*W-1:0] cpl, string tag);
        exp_t e;
        ia.in_valid  = 1'b1;
        ia.increment = W'(inc);
        ia.coupling  = cpl;
        model_beat(inc, cpl);
        q.push_back(snap());
        step();
        ia.in_valid = 1'b0;
        e = q.pop_front();
        compare(e, tag);
    endtask

    task automatic start_run(bit ld, int lv, int n);
        ia.load_en    = ld;
        ia.load_value = W'(lv);
        ia.start      = 1'b1;
        ia.steps      = SW'(n);
        step();
        ia.load_en = 1'b0;
        ia.start   = 1'b0;
        if (ld) model_set(lv, 1'b1);
        else model_set_flip_only();
    endtask

    function automatic void model_set_flip_only();
        mf[0] = 0;
        mf[1] = 0;
    endfunction

    initial begin
        rst = 1'b1;
        ia.load_en = 1'b0; ia.load_value = '0; ia.start = 1'b0; ia.steps = '0;
        ia.in_valid = 1'b0; ia.increment = '0; ia.coupling = '0;
        model_set(0, 1'b1);
        step();
        step();
        rst = 1'b0;
        compare(snap(), "reset");
        chk("reset/in_ready", 32'(ia.in_ready), 0);
        chk("reset/busy", 32'(ia.busy), 0);
        chk("reset/done", 32'(ia.done), 0);

        ia.load_en = 1'b1; ia.load_value = W'(-3);
        step();
        ia.load_en = 1'b0;
        model_set(-3, 1'b0);
        compare(snap(), "load");
        chk("load/raw", ia.value, 32'hFDFDFDFD);

        start_run(1'b1, 0, 3);
        compare(snap(), "basic/start");
        chk("basic/busy0", 32'(ia.busy), 1);
        chk("basic/ready0", 32'(ia.in_ready), 1);
        beat(1, {8'd4, 8'd3, 8'd2, 8'd1}, "basic/b1");
        chk("basic/busy1", 32'(ia.busy), 1);
        beat(1, {8'd4, 8'd3, 8'd2, 8'd1}, "basic/b2");
        chk("basic/busy2", 32'(ia.busy), 1);
        beat(1, {8'd4, 8'd3, 8'd2, 8'd1}, "basic/b3");
        chk("basic/raw", ia.value, 32'h0F0C0906);
        chk("basic/busy3", 32'(ia.busy), 0);
        chk("basic/done", 32'(ia.done), 1);
        chk("basic/ready_done", 32'(ia.in_ready), 0);
        step();
        chk("basic/done_off", 32'(ia.done), 0);
        chk("basic/idle_ready", 32'(ia.in_ready), 0);

        start_run(1'b1, 120, 1);
        beat(10, '0, "sat");
        chk("sat/raw_sat", ia.value, 32'h7F7F7F7F);
        chk("sat/raw_wrap", ib.value, 32'h82828282);
        chk("sat/flip_wrap", 32'(ib.flip_count), 4);
        chk("sat/done", 32'(ia.done), 1);
        step();

        start_run(1'b1, -1, 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ia.start = 1'b1; ia.steps = SW'(9); ia.load_en = 1'b1; ia.load_value = W'(50);
            end
            step();
            ia.start = 1'b0; ia.load_en = 1'b0;
            compare(snap(), "stall/gap1");
            chk("stall/busy1", 32'(ia.busy), 1);
        end
        beat(2, '0, "stall/b1");
        chk("stall/raw1", ia.value, 32'h01010101);
        for (int i = 0; i < 5; i++) begin
            step();
            compare(snap(), "stall/gap2");
        end
        beat(2, '0, "stall/b2");
        chk("stall/raw2", ia.value, 32'h03030303);
        chk("stall/flip2", 32'(ia.flip_count), 4);
        chk("stall/done", 32'(ia.done), 1);
        step();

        start_run(1'b1, -1, 2);
        beat(2, '0, "fsat/b1");
        beat(-4, '0, "fsat/b2");
        chk("fsat/flip", 32'(ia.flip_count), 7);
        chk("fsat/done", 32'(ia.done), 1);
        step();

        ia.in_valid = 1'b1; ia.increment = W'(5);
        step();
        step();
        ia.in_valid = 1'b0;
        compare(snap(), "idle_valid");
        chk("idle_valid/ready", 32'(ia.in_ready), 0);

        start_run(1'b0, 0, 0);
        chk("zero/done", 32'(ia.done), 1);
        chk("zero/busy", 32'(ia.busy), 0);
        compare(snap(), "zero");
        step();
        chk("zero/done_off", 32'(ia.done), 0);
        chk("zero/busy_off", 32'(ia.busy), 0);

        start_run(1'b0, 0, 1);
        beat(1, '0, "b2b/b1");
        chk("b2b/done", 32'(ia.done), 1);
        ia.start = 1'b1; ia.steps = SW'(4);
        step();
        chk("b2b/ignored_busy", 32'(ia.busy), 0);
        chk("b2b/ignored_done", 32'(ia.done), 0);
        step();
        ia.start = 1'b0;
        model_set_flip_only();
        chk("b2b/accepted", 32'(ia.busy), 1);
        beat(1, '0, "midrst/b1");
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_set(0, 1'b1);
        compare(snap(), "midrst");
        chk("midrst/busy", 32'(ia.busy), 0);
        chk("midrst/ready", 32'(ia.in_ready), 0);
        chk("midrst/done", 32'(ia.done), 0);

        start_run(1'b0, 0, 2);
        beat(1, '0, "after/b1");
        chk("after/busy", 32'(ia.busy), 1);
        beat(1, '0, "after/b2");
        chk("after/raw", ia.value, 32'h02020202);
        chk("after/done", 32'(ia.done), 1);
        step();
        chk("after/idle", 32'(ia.in_ready), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spin_array.md
# spin_array

Parametrised array of SPINS signed spin accumulators with an annealing-run controller. Each accepted input beat adds a shared increment plus a per-spin coupling term to every accumulator, with either saturating or wrapping arithmetic. A run lasts a programmed number of beats, and the block counts spin sign flips over the run. It sits between the coupling-matrix engine, which produces coupling beats, and the readout/host logic, which loads initial state, starts runs and reads spins.

## Interface
- WIDTH, 32: accumulator width in bits, two's complement signed; minimum 4.
- SPINS, 32: number of spin accumulators.
- SATURATE, 1: 1 = clamp on overflow, 0 = modulo-2^WIDTH wrap.
- STEP_W, 16: width of the run-length counter.
- FLIP_W, 16: width of the flip counter.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- load_en  in  1  IDLE only: write load_value into every accumulator.
- load_value  in  WIDTH  signed initial accumulator value.
- start  in  1  IDLE only: begin a run of `steps` beats.
- steps  in  STEP_W  run length, sampled when start is accepted.
- in_valid  in  1  coupling beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready; equals (state == RUN).
- increment  in  WIDTH  signed term shared by all spins.
- coupling  in  SPINS*WIDTH  signed per-spin terms; spin s uses bits [s*WIDTH +: WIDTH].
- value  out  SPINS*WIDTH  accumulator registers, same packing as coupling.
- spin  out  SPINS  spin[s] = ~value[s] MSB: 1 when non-negative, 0 when negative.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- flip_count  out  FLIP_W  spin sign changes accumulated over the current or last run.

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - start=1 with steps>0: step counter <= steps, flip_count <= 0, go to RUN.
  - start=1 with steps=0: flip_count <= 0, go to DONE; no accumulator updates.
  - If load_en and start are both asserted: the load is applied and the run also starts; the first beat sees the loaded values.
- RUN
  - On each accepted beat, for every s: sum = value[s] + increment + coupling[s], computed in WIDTH+2 signed bits.
  - SATURATE=1: clamp sum to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. SATURATE=0: keep the low WIDTH bits.
  - Per beat, flip_count += popcount of spins whose sign bit changed.
  - flip_count saturates at 2^FLIP_W-1; it never wraps.
  - Step counter decrements per beat. The beat with counter = 1 moves the state to DONE.
  - Cycles without in_valid hold all state.
- DONE: done=1 for exactly one cycle, in_ready=0, then IDLE.
- Ignored inputs:
  - start and load_en outside IDLE.
  - in_valid outside RUN; value does not change.
- Retention: flip_count and value hold after the run until the next start or load.
- Reset, any state, mid-run included:
  - state IDLE; all value = 0; spin = all 1s.
  - busy = 0, done = 0, in_ready = 0, flip_count = 0, step counter = 0.

## Timing
- Load: value reflects load_value on the edge where load_en is sampled in IDLE.
- Start: busy and in_ready assert one cycle after start is sampled.
- Beat latency: value, spin and flip_count update on the edge that accepts the beat (1-cycle latency).
- Run length: a run of N beats with in_valid held high gives busy high for N cycles, then done high for 1 cycle, then IDLE.
- Minimum start-to-start interval: N+2 cycles.
- steps=0: done pulses in the cycle after start; busy never asserts.
- Back-to-back starts: start asserted during DONE is ignored; it is accepted on the first IDLE cycle.

## Test plan
- Reset and load (WIDTH=8, SPINS=4)
  - After rst: all value=0, spin=4'b1111, flip_count=0, in_ready=0.
  - load_en with load_value=-3 -> every value=8'hFD, spin=4'b0000.
- Basic run
  - From value=0: start, steps=3; three beats of increment=1, coupling={4,3,2,1}.
  - Required: values {15,12,9,6}; done exactly one cycle after the 3rd beat; busy high for exactly 3 cycles.
- Saturation vs wrap
  - Setup: value=120, increment=10, coupling=0, one beat.
  - SATURATE=1 -> 127, spin stays 1, flip_count=0.
  - SATURATE=0 -> -126 (8'h82), spin=0, flip_count=4.
- Stalls and flips
  - Setup: start steps=2 from value=-1; in_valid gaps of 5 cycles; increment=2, coupling=0.
  - Required: values change only on accepted beats; after beat 1 value=1 and flip_count=4; after beat 2 value=3 and flip_count=4.
- Ignored controls
  - start and load_en asserted during RUN -> no restart, no load, step count unaffected.
  - in_valid in IDLE -> value unchanged.
  - steps=0 -> done the next cycle, value unchanged.
- Reset mid-run
  - rst after 1 of 4 beats -> next cycle: state IDLE, value=0, busy=0, flip_count=0.
  - A new run then completes normally.
